// File: rtl/dmem_handshake_ctrl.sv
// M-stage data-memory controller: req/stall/done handshake toward a multi-cycle memory.
// Optional WAIT timeout abort is compiled in with DMEM_TIMEOUT_EN.
module dmem_handshake_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [DATA_W-1:0] wrDataM,
    output logic [DATA_W-1:0] memOutM,
    output logic              dmemStall,
    output logic              err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              is_read_q, is_read_d;
    logic              access;
    logic              aligned;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    assign access    = memReadM | memWriteM;
    assign aligned   = ~addrM[0];
    assign mem_wr    = memWriteM;
    assign mem_addr  = addrM;
    assign mem_wdata = wrDataM;
    // err_d already contains err_q, so a fresh error is visible in the cycle it is detected
    assign err       = rst & err_d;

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        is_read_d = is_read_q;
        mem_en    = 1'b0;
        dmemStall = 1'b0;
        memOutM   = rdata_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (!aligned) begin
                        err_d = 1'b1;
                    end else begin
                        mem_en = 1'b1;
                        if (mem_stall) begin
                            dmemStall = 1'b1;
                        end else if (mem_done) begin
                            if (!memWriteM) begin
                                memOutM = mem_rdata;
                                rdata_d = mem_rdata;
                            end
                        end else begin
                            dmemStall = 1'b1;
                            is_read_d = ~memWriteM;
                            state_d   = WAIT;
`ifdef DMEM_TIMEOUT_EN
                            cnt_d     = '0;
`endif
                        end
                    end
                end
            end
            WAIT: begin
                dmemStall = 1'b1;
                if (mem_done) begin
                    if (is_read_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs must show reset values while rst is held, independent of inputs
        if (!rst) begin
            mem_en    = 1'b0;
            dmemStall = 1'b0;
            memOutM   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            is_read_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            is_read_q <= is_read_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule
